// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that lets four requesters take turns loading a shared register.
// Optional macro REG_ARB_CNT_EN adds a saturating 16-bit count of completed loads (load_cnt).
module reg_load_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] reg_din,
    output logic             reg_load,
    output logic             busy,
`ifdef REG_ARB_CNT_EN
    output logic [15:0]      load_cnt,
`endif
    output logic [1:0]       owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_last;
    logic [1:0]       r_owner;
    logic [3:0]       r_ack;
    logic             r_reg_load;
    logic             r_busy;

    logic [WIDTH-1:0] w_din [4];
    logic [1:0]       w_winner;
    logic             w_found;
    logic [3:0]       w_owner_onehot;

    assign w_din[0] = din0;
    assign w_din[1] = din1;
    assign w_din[2] = din2;
    assign w_din[3] = din3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign w_owner_onehot[gi] = (r_owner == 2'(gi));
        end
    endgenerate

    // Search starts just after the last-serviced requester and wraps; offset 4 lands back on last.
    always_comb begin
        logic [1:0] cand;
        w_winner = 2'd0;
        w_found  = 1'b0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = r_last + 2'(k);
            if (!w_found && req[cand]) begin
                w_winner = cand;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_last     <= 2'd3;
            r_owner    <= 2'd0;
            r_ack      <= 4'b0000;
            r_reg_load <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack      <= 4'b0000;
                    r_reg_load <= 1'b0;
                    r_busy     <= 1'b0;
                    if (w_found) begin
                        r_data     <= w_din[w_winner];
                        r_owner    <= w_winner;
                        r_reg_load <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_reg_load <= 1'b0;
                    r_ack      <= w_owner_onehot;
                    r_busy     <= 1'b1;
                    r_state    <= ACK;
                end
                ACK: begin
                    r_ack   <= 4'b0000;
                    r_busy  <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack      <= 4'b0000;
                    r_reg_load <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

`ifdef REG_ARB_CNT_EN
    logic [15:0] r_load_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_cnt <= 16'd0;
        end else if (r_state == LOAD && r_load_cnt != 16'hFFFF) begin
            r_load_cnt <= r_load_cnt + 16'd1;
        end
    end

    assign load_cnt = r_load_cnt;
`endif

    assign ack      = r_ack;
    assign reg_din  = r_data;
    assign reg_load = r_reg_load;
    assign busy     = r_busy;
    assign owner    = r_owner;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: single request, contention, data hold, withdrawal, reset abort.
module tb_reg_load_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [WIDTH-1:0] din0, din1, din2, din3;
    logic [3:0]       ack;
    logic [WIDTH-1:0] reg_din;
    logic             reg_load;
    logic             busy;
    logic [1:0]       owner;
`ifdef REG_ARB_CNT_EN
    logic [15:0]      load_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    reg_load_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .din0     (din0),
        .din1     (din1),
        .din2     (din2),
        .din3     (din3),
        .ack      (ack),
        .reg_din  (reg_din),
        .reg_load (reg_load),
        .busy     (busy),
`ifdef REG_ARB_CNT_EN
        .load_cnt (load_cnt),
`endif
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] seq_din [5];
        logic [1:0] seq_own [5];
        seq_din = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        seq_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reset = 1'b1; req = 4'b0000;
        din0 = 8'h00; din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;
        step(); step();
        check("rst_reg_load", 32'(reg_load), 32'd0);
        check("rst_ack",      32'(ack),      32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_reg_din",  32'(reg_din),  32'd0);
        check("rst_owner",    32'(owner),    32'd0);
`ifdef REG_ARB_CNT_EN
        check("rst_load_cnt", 32'(load_cnt), 32'd0);
`endif
        reset = 1'b0;
        step();
        check("idle_no_req_load", 32'(reg_load), 32'd0);
        $display("txn reset: done");

        // Single request from requester 2
        req = 4'b0100; din2 = 8'hA5;
        step();
        check("single_load",    32'(reg_load), 32'd1);
        check("single_reg_din", 32'(reg_din),  32'hA5);
        check("single_owner",   32'(owner),    32'd2);
        check("single_busy",    32'(busy),     32'd1);
        check("single_no_ack",  32'(ack),      32'd0);
        step();
        check("single_ack",       32'(ack),      32'b0100);
        check("single_ack_noload",32'(reg_load), 32'd0);
        req = 4'b0000;
        step();
        check("single_idle_ack",  32'(ack),  32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);
        $display("txn single: owner=%0d reg_din=%h", owner, reg_din);

        // Full contention, starting from a fresh reset (last=3)
        reset = 1'b1; step(); reset = 1'b0;
        din0 = 8'h10; din1 = 8'h20; din2 = 8'h30; din3 = 8'h40;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_load",    32'(reg_load), 32'd1);
            check("rr_reg_din", 32'(reg_din),  32'(seq_din[k]));
            check("rr_owner",   32'(owner),    32'(seq_own[k]));
            step();
            check("rr_ack", 32'(ack), 32'(4'b0001 << seq_own[k]));
            if (k == 4) req = 4'b0000;
            step();
            check("rr_idle_busy", 32'(busy), 32'd0);
            $display("txn rr%0d: owner=%0d reg_din=%h", k, seq_own[k], seq_din[k]);
        end

        // Data change after capture (last=0, so requester 1 wins)
        req = 4'b0010; din1 = 8'h11;
        step();
        check("hold_reg_din_load", 32'(reg_din), 32'h11);
        din1 = 8'hEE;
        step();
        check("hold_reg_din_ack", 32'(reg_din), 32'h11);
        check("hold_ack",         32'(ack),     32'b0010);
        req = 4'b0000;
        step();
        $display("txn hold: reg_din=%h", reg_din);

        // Requester 0 withdraws after one cycle (last=1)
        req = 4'b0001; din0 = 8'h5A;
        step();
        req = 4'b0000;
        check("wd_load",    32'(reg_load), 32'd1);
        check("wd_reg_din", 32'(reg_din),  32'h5A);
        step();
        check("wd_ack", 32'(ack), 32'b0001);
        step();
        check("wd_idle_busy", 32'(busy), 32'd0);
        $display("txn withdraw: ack seen for requester 0");

        // Reset in the ACK cycle aborts the ack (last=0, requester 2 wins)
        req = 4'b0100; din2 = 8'h77; din0 = 8'h10;
        step();
        step();
        check("rmid_ack_before", 32'(ack), 32'b0100);
        reset = 1'b1; req = 4'b1111;
        step();
        reset = 1'b0;
        check("rmid_ack",     32'(ack),     32'd0);
        check("rmid_busy",    32'(busy),    32'd0);
        check("rmid_reg_din", 32'(reg_din), 32'd0);
        check("rmid_owner",   32'(owner),   32'd0);
        step();
        check("rmid_grant_owner", 32'(owner),   32'd0);
        check("rmid_grant_din",   32'(reg_din), 32'h10);
        req = 4'b0000;
        step(); step();
        check("rmid_no_ack_after", 32'(busy), 32'd0);
        $display("txn reset_mid: next grant owner=0");

`ifdef REG_ARB_CNT_EN
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 15; k++) step();
        req = 4'b0000;
        check("cnt_five", 32'(load_cnt), 32'd5);
        $display("txn counter: load_cnt=%0d", load_cnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of each requester and of the shared register.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port req  input  4  per-requester load request, bit i = requester i.
REQ-005 The block SHALL have ports din0, din1, din2, din3  input  WIDTH  data offered by requesters 0-3.
REQ-006 The block SHALL have port ack  output  4  one-cycle pulse to the serviced requester, one-hot or zero.
REQ-007 The block SHALL have port reg_din  output  WIDTH  data driven to the shared register's din.
REQ-008 The block SHALL have port reg_load  output  1  load strobe to the shared register: 1 = load, 0 = hold.
REQ-009 The block SHALL have port busy  output  1  high in states LOAD and ACK.
REQ-010 The block SHALL have port owner  output  2  index of the current or last-serviced requester.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, LOAD and ACK.
REQ-012 In IDLE with req != 0, the block SHALL pick a winner round-robin, searching from (last+1) mod 4 upward with wrap.
- Same edge: capture the winner's din into an internal WIDTH-bit data register.
- Same edge: set owner to the winner and move to LOAD.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE, with reg_load=0 and ack=0.
REQ-014 LOAD SHALL last exactly one cycle, with reg_load=1 and reg_din=captured data, then move to ACK.
REQ-015 ACK SHALL last exactly one cycle, with ack[owner]=1 and reg_load=0.
- Same edge: set last=owner and move to IDLE.
REQ-016 Outside LOAD, reg_load SHALL be 0; reg_din SHALL always equal the captured data register, never a live din input.
REQ-017 Request-to-load latency SHALL be 1 cycle: req sampled in IDLE at edge N gives reg_load high in cycle N+1 and ack in cycle N+2.
- Peak throughput: one load per 3 cycles.
REQ-018 A requester SHALL keep req and its din stable until ack; data is sampled only at the IDLE->LOAD edge.
REQ-019 If the winner drops req during LOAD or ACK, the block SHALL still complete the transaction.
REQ-020 A req still high in the cycle after ack SHALL be treated as a new request.
- Round-robin fairness: a continuously requesting source waits for every other pending source before its next grant.
REQ-021 Requests arriving in LOAD or ACK SHALL be ignored until the next IDLE; no queueing.
REQ-022 Winner selection with all four req bits high SHALL rotate strictly 0,1,2,3,0... from last=3.

Reset
REQ-023 With reset=1 at a rising edge, the block SHALL go to IDLE, with captured data=0, last=3, owner=0.
- If REG_ARB_CNT_EN is defined, load_cnt SHALL also clear to 0.
REQ-024 After reset, outputs SHALL be reg_load=0, ack=0, busy=0, reg_din=0, owner=0.
REQ-025 Reset SHALL take priority over every other event.
- Reset in LOAD or ACK aborts the transaction, with no ack pulse issued afterwards.

Configuration
REQ-026 Macro REG_ARB_CNT_EN SHALL, when defined, add output load_cnt  output  16  count of completed LOAD cycles.
- load_cnt increments at each LOAD->ACK edge.
- load_cnt saturates at 16'hFFFF (no wrap).
REQ-027 Without REG_ARB_CNT_EN, port load_cnt and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 Single request: reset, then req=4'b0100, din2=8'hA5 -> reg_load=1 with reg_din=8'hA5 one cycle later, then ack=4'b0100 the next cycle, then idle.
REQ-029 Full contention: req=4'b1111 held, din0..din3=8'h10,8'h20,8'h30,8'h40 -> reg_din sequence 10,20,30,40,10 on successive LOAD cycles, each 3 cycles apart.
REQ-030 Din change after capture: din1 changes from 8'h11 to 8'hEE during LOAD -> reg_din remains 8'h11 and the register captures 8'h11.
REQ-031 Reset mid-operation: reset=1 in the ACK cycle -> next cycle ack=0, busy=0, reg_din=0, and the next grant with req=4'b1111 goes to requester 0.
REQ-032 Request withdrawal: req=4'b0001 for one cycle only -> full LOAD and ACK still occur with ack=4'b0001.
REQ-033 With REG_ARB_CNT_EN: 5 serviced requests -> load_cnt=5; counter preloaded to 16'hFFFE plus 3 loads -> 16'hFFFF.
